if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the single-issue RV32I core.
- Owns the program counter and drives the combinational instruction ROM (`imem`) address.
- Registers the returned word plus its PC into the IF/ID pipeline register, which feeds decode over a valid/ready handshake.
- Handles stall from decode and redirect (branch/jump/trap target) from execute.

Parameters:
- RESET_VEC, 32'h00000000, PC value loaded on reset.
- XLEN, 32, address/instruction width; only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  global fetch enable; low = no new fetch.
- imem_addr  out  32  byte address to imem; combinational copy of pc.
- imem_instr  in  32  instruction word returned by imem in the same cycle.
- redirect_valid  in  1  one-cycle pulse: load pc from redirect_pc, flush IF/ID.
- redirect_pc  in  32  redirect target byte address.
- id_valid  out  1  IF/ID holds a valid instruction.
- id_ready  in  1  decode accepts IF/ID this cycle.
- id_instr  out  32  registered instruction.
- id_pc  out  32  registered PC of id_instr.
- pc_out  out  32  current fetch PC (debug).

Behaviour:
- Reset (async, immediate, also mid-operation):
  - pc = RESET_VEC.
  - id_valid = 0.
  - id_instr = 32'h00000013 (NOP, addi x0,x0,0).
  - id_pc = 0.
- imem_addr = pc = pc_out, purely combinational. imem has zero latency, so fetch takes one cycle: the word at pc appears on id_instr one clock edge later.
- adv = fetch_en && (!id_valid || id_ready).
- Priority per rising edge, highest first:
  - redirect_valid:
    - pc <= {redirect_pc[31:2],2'b00}.
    - id_valid <= 0. id_instr and id_pc are unchanged.
    - The fetch in flight this cycle is discarded.
  - adv:
    - id_instr <= imem_instr; id_pc <= pc; id_valid <= 1.
    - pc <= pc + 4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
  - id_valid && id_ready && !fetch_en: id_valid <= 0; pc holds.
  - otherwise (stall: id_valid && !id_ready): pc, id_instr, id_pc, id_valid all hold.
- Simultaneous redirect_valid and id_ready: the IF/ID content is consumed by decode and no new instruction is captured. The first post-redirect instruction appears on id_instr one edge after the redirect edge.
- Back-to-back redirects: the last one wins; id_valid stays 0 throughout.
- id_instr/id_pc are stable while id_valid && !id_ready; they change only when a transfer completes or on reset.
- Throughput: one instruction per cycle when id_ready = 1 and fetch_en = 1.
- No internal FSM beyond the state run/stall/flush implied by the priorities above; pc is the only counter.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misalign (1 bit), set when redirect_valid && redirect_pc[1:0] != 0.
  - pc is still loaded with redirect_pc aligned down.
  - fetch_misalign is registered: high for exactly one cycle after the redirect edge, and cleared by reset.
  - Trap handling is upstream's responsibility.
- Undefined:
  - No fetch_misalign port.
  - Redirect targets are silently aligned down ({redirect_pc[31:2],2'b00}).

Decomposition:
- Shared defines file gains:
  - INSTR_NOP = 32'h00000013.
  - PC_STEP = 4.
  - Default RESET_VEC value.
- One natural sub-module: if_id_reg, the IF/ID pipeline register holding valid/instr/pc with load, hold and flush controls.
- The PC register and priority logic stay in if_stage.

Test Plan:
- Reset then id_ready=1, fetch_en=1 with the standard imem image:
  - Cycle 1: id_instr = 40000593, id_pc = 0.
  - Then 40058593 @ 4, 0145a803 @ 8, fe080ee3 @ C, one per cycle.
- Stall: drop id_ready while id_instr = 0145a803 for 3 cycles.
  - id_instr/id_pc/pc hold for 3 cycles.
  - On release, the next word is fe080ee3 @ 0xC, with no skipped or duplicated PC.
- Redirect to 0x000000B4 during a stall:
  - The next cycle has id_valid = 0.
  - The following cycle has id_instr = 407b8bb3, id_pc = 0xB4.
- Redirect to 0x000000C6:
  - pc = 0xC4 and id_instr = f45ff0ef.
  - fetch_misalign pulses for one cycle only when IF_MISALIGN_TRAP_EN is defined.
- Redirect to 0xFFFFFFFC, then one advance: id_pc = FFFFFFFC and pc wraps to 0x00000000.
- Assert rst asynchronously mid-stream (between edges):
  - pc = 0 and id_valid = 0 immediately.
  - After release, fetch restarts at 40000593.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and helpers for the RV32I instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] INSTR_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc with flush > load > hold priority.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    // Flush only drops valid; instr/pc keep their last transferred content.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= INSTR_NOP;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns pc, drives imem, fills IF/ID over valid/ready.
// Optional IF_MISALIGN_TRAP_EN adds a registered fetch_misalign pulse output.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter int          XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
`ifdef IF_MISALIGN_TRAP_EN
    output logic            fetch_misalign,
`endif
    output logic [XLEN-1:0] pc_out
);

    logic [XLEN-1:0] pc;
    logic            adv;
    logic            drain;
    logic            flush;

    // Capture when IF/ID is empty or is being consumed this cycle.
    assign adv   = fetch_en && (!id_valid || id_ready);
    // Decode takes the last word while fetch is disabled: IF/ID empties.
    assign drain = id_valid && id_ready && !fetch_en;
    assign flush = redirect_valid || drain;

    assign imem_addr = pc;
    assign pc_out    = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (adv) begin
            pc <= pc + PC_STEP;
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (adv),
        .flush    (flush),
        .instr_in (imem_instr),
        .pc_in    (pc),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc)
    );

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_misalign <= 1'b0;
        end else begin
            fetch_misalign <= redirect_valid && is_misaligned(redirect_pc);
        end
    end
`endif

endmodule
